cmp_int_serial: RTL

Parametrised, multi-cycle signed/unsigned integer comparator for the pimsynth benchmark set. It generalises the fixed 32-bit combinational greater-than into a digit-serial engine. It compares MSB-first, DIGIT bits per cycle, which matches the row-by-row evaluation a PIM array performs. It supports six comparison predicates and a run-time signed/unsigned mode, and sits behind a valid/ready handshake on both sides.

---
 rtl/cmp_serial_pkg.sv | 44 ++++
 rtl/cmp_digit.sv | 14 +
 rtl/cmp_int_serial.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cmp_serial_pkg.sv
// Shared types and helpers for the digit-serial integer comparator.
package cmp_serial_pkg;

    // Comparison predicate codes; codes 6 and 7 are reserved and evaluate to 0.
    typedef enum logic [2:0] {
        CMP_GT   = 3'd0,
        CMP_GE   = 3'd1,
        CMP_LT   = 3'd2,
        CMP_LE   = 3'd3,
        CMP_EQ   = 3'd4,
        CMP_NE   = 3'd5,
        CMP_RSV6 = 3'd6,
        CMP_RSV7 = 3'd7
    } cmp_op_e;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    // Digit counter width: enough to hold N-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Map the resolved lt/eq/gt flags onto the requested predicate.
    function automatic logic cmp_eval(input cmp_op_e op, input logic lt,
                                      input logic eq, input logic gt);
        logic r;
        case (op)
            CMP_GT:  r = gt;
            CMP_GE:  r = gt | eq;
            CMP_LT:  r = lt;
            CMP_LE:  r = lt | eq;
            CMP_EQ:  r = eq;
            CMP_NE:  r = ~eq;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// Unsigned compare of one DIGIT-bit slice of each operand.
module cmp_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             eq
);

    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/cmp_int_serial.sv
// Digit-serial signed/unsigned integer comparator, MSB first, DIGIT bits per
// cycle, valid/ready on both sides.
// Optional build macro: CMP_SERIAL_EARLY_EXIT_EN -- leave RUN on the cycle
// the first differing digit resolves instead of always walking all N digits.
module cmp_int_serial
    import cmp_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Y,
    output logic             busy
);

    localparam int DIGIT_S = (DIGIT < 1) ? 1 : DIGIT;
    localparam int N       = WIDTH / DIGIT_S;
    localparam int CW      = cnt_width(N);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT_S) != 0) begin : g_bad_cfg
        $error("cmp_int_serial: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
    end

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    cmp_op_e          op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             y_q, y_d;
    logic             out_valid_q, out_valid_d;
    logic             dig_lt, dig_eq;
    logic             fin;

    cmp_digit #(.DIGIT(DIGIT_S)) u_digit (
        .a  (a_q[WIDTH-1 -: DIGIT_S]),
        .b  (b_q[WIDTH-1 -: DIGIT_S]),
        .lt (dig_lt),
        .eq (dig_eq)
    );

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign Y         = y_q;

    // Next-state, datapath shift and result computation.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        lt_d        = lt_q;
        gt_d        = gt_q;
        eq_d        = eq_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        fin         = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    // Flipping the sign bit maps two's complement order onto
                    // unsigned order, so RUN only ever does unsigned compares.
                    a_d     = A ^ (is_signed ? MSB_MASK : '0);
                    b_d     = B ^ (is_signed ? MSB_MASK : '0);
                    op_d    = cmp_op_e'(op);
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    cnt_d   = CW'(N - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                // The first differing digit decides; later digits are ignored.
                if (eq_q && !dig_eq) begin
                    eq_d = 1'b0;
                    lt_d = dig_lt;
                    gt_d = ~dig_lt;
                end
                a_d   = a_q << DIGIT_S;
                b_d   = b_q << DIGIT_S;
                cnt_d = cnt_q - 1'b1;
`ifdef CMP_SERIAL_EARLY_EXIT_EN
                fin = (cnt_q == '0) || (eq_q && !dig_eq);
`else
                fin = (cnt_q == '0);
`endif
                if (fin) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    y_d         = cmp_eval(op_q, lt_d, eq_d, gt_d);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= CMP_GT;
            cnt_q       <= '0;
            lt_q        <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b1;
            y_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            lt_q        <= lt_d;
            gt_q        <= gt_d;
            eq_q        <= eq_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
